ps2_frame_receiver: RTL



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_scancode_fifo.sv | 79 +++++++
 rtl/ps2_frame_receiver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scancode receiver: the frame FSM state
// type, the fixed PS/2 frame constants and a parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int   DATA_BITS       = 8;
    localparam logic START_BIT_VALUE = 1'b0;
    localparam logic STOP_BIT_VALUE  = 1'b1;

    // PS/2 uses odd parity: the eight data bits plus the parity bit must
    // contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 parity);
        return ^{parity, data};
    endfunction

endpackage

// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo
// First-word fall-through scancode buffer, FIFO_DEPTH entries of 8 bits.
// FIFO_DEPTH must be a power of two and at least 2.
//
// Ports:
//   clock      chipset clock, rising edge
//   reset      synchronous, active-high; empties the buffer
//   push       write push_data (accepted when not full, or full with a pop)
//   push_data  byte to write
//   pop        remove the head entry (ignored while empty)
//   head       head entry, forced to 0 while empty
//   full       count == FIFO_DEPTH
//   empty      count == 0
//   count      occupancy, 0..FIFO_DEPTH
module ps2_scancode_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_BITS-1:0]          push_data,
    input  logic                          pop,
    output logic [DATA_BITS-1:0]          head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count_q;
    logic                 pop_ok;
    logic                 push_ok;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A pop frees the head slot first, so a push into a full buffer is still
    // accepted when it coincides with a real pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
// Deserialises PS/2 keyboard frames (start, 8 data LSB-first, odd parity,
// stop) from synchronised ps2_clock/ps2_data into scancode bytes, buffers
// them in a small FWFT FIFO and inhibits the device while the FIFO is full.
//
// Ports:
//   clock           chipset clock, rising edge
//   reset           synchronous, active-high
//   ps2_clock       PS/2 clock, already synchronised
//   ps2_data        PS/2 data, already synchronised
//   ps2_clock_out   0 pulls the PS/2 clock low (inhibit), 1 releases it
//   scancode        FIFO head byte, valid while scancode_valid=1
//   scancode_valid  FIFO not empty
//   scancode_read   pop the head entry
//   parity_error    sticky, bad odd parity seen
//   framing_error   sticky, stop bit 0 or frame timeout
//   overflow        sticky, good byte arrived with the FIFO full
//   error_clear     clears the sticky flags (a same-cycle set wins)
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ps2_clock,
    input  logic                 ps2_data,
    output logic                 ps2_clock_out,
    output logic [DATA_BITS-1:0] scancode,
    output logic                 scancode_valid,
    input  logic                 scancode_read,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overflow,
    input  logic                 error_clear
);

    localparam int FILT_W = $clog2(FILTER_CYCLES);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic                 filt_clk;
    logic [FILT_W-1:0]    filt_cnt;
    logic                 filt_differ;
    logic                 filt_flip;
    logic                 sample_event;

    ps2_state_t           state;
    ps2_state_t           state_next;
    logic [2:0]           bit_count;
    logic [2:0]           bit_count_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 parity_bit;
    logic                 parity_next;
    logic [TO_W-1:0]      timeout_cnt;
    logic [TO_W-1:0]      timeout_next;

    logic                 byte_push;
    logic                 set_parity_err;
    logic                 set_framing_err;
    logic                 set_overflow;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    // Clock filter: the filtered clock follows ps2_clock only after the input
    // has disagreed for FILTER_CYCLES consecutive cycles. The sample event is
    // the cycle in which the filtered clock is committed from 1 to 0.
    assign filt_differ  = (ps2_clock != filt_clk);
    assign filt_flip    = filt_differ && (filt_cnt == FILT_W'(FILTER_CYCLES - 1));
    assign sample_event = filt_flip && filt_clk;

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (!filt_differ) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= ps2_clock;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_count   <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state       <= state_next;
            bit_count   <= bit_count_next;
            shift_reg   <= shift_next;
            parity_bit  <= parity_next;
            timeout_cnt <= timeout_next;
        end
    end

    // Frame FSM. A sample event always takes priority over the timeout since
    // it proves the device is still clocking.
    always_comb begin
        state_next      = state;
        bit_count_next  = bit_count;
        shift_next      = shift_reg;
        parity_next     = parity_bit;
        timeout_next    = timeout_cnt + TO_W'(1);
        byte_push       = 1'b0;
        set_parity_err  = 1'b0;
        set_framing_err = 1'b0;

        if (state == IDLE) begin
            timeout_next = '0;
            if (sample_event && (ps2_data == START_BIT_VALUE)) begin
                state_next     = DATA;
                bit_count_next = '0;
            end
        end else if (sample_event) begin
            timeout_next = '0;
            unique case (state)
                DATA: begin
                    shift_next     = {ps2_data, shift_reg[DATA_BITS-1:1]};
                    bit_count_next = bit_count + 3'd1;
                    if (bit_count == 3'(DATA_BITS - 1)) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = ps2_data;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (ps2_data != STOP_BIT_VALUE) begin
                        set_framing_err = 1'b1;
                    end else if (!odd_parity_ok(shift_reg, parity_bit)) begin
                        set_parity_err = 1'b1;
                    end else begin
                        byte_push = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_next      = IDLE;
            timeout_next    = '0;
            set_framing_err = 1'b1;
        end
    end

    // A good byte is only lost when the FIFO is full and no real pop frees a
    // slot in the same cycle.
    assign set_overflow = byte_push && fifo_full && !(scancode_read && !fifo_empty);

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (set_parity_err) begin
                parity_error <= 1'b1;
            end else if (error_clear) begin
                parity_error <= 1'b0;
            end
            if (set_framing_err) begin
                framing_error <= 1'b1;
            end else if (error_clear) begin
                framing_error <= 1'b0;
            end
            if (set_overflow) begin
                overflow <= 1'b1;
            end else if (error_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    ps2_scancode_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (byte_push),
        .push_data (shift_reg),
        .pop       (scancode_read),
        .head      (scancode),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign scancode_valid = !fifo_empty;

    // Decoded straight from the registered occupancy count.
    assign ps2_clock_out = (fifo_count != CNT_W'(FIFO_DEPTH));

endmodule
